// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
//   Shared video constants: the default 640x480@60 timing set and the counter
//   widths used by the timing generator, the video output stage and the
//   display controllers. Also holds a small window-decode helper.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  // Counter widths: pixel_x covers totals up to 2048, pixel_y up to 1024.
  localparam int VGA_X_W = 11;
  localparam int VGA_Y_W = 10;

  localparam int VGA_H_TOTAL_MAX = 1 << VGA_X_W;
  localparam int VGA_V_TOTAL_MAX = 1 << VGA_Y_W;

  // 640x480@60 with a 25.175 MHz pixel clock.
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  // True when lo <= v <= hi (inclusive window).
  function automatic logic in_window(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
//   Horizontal/vertical raster counters plus sync/blank decode for a VGA-style
//   display. Every output is a register; the flags are decoded from the
//   next-state counter values so they describe exactly the pixel presented on
//   pixel_x/pixel_y in the same cycle.
//
// Ports
//   pixel_clock  in   sole clock, rising edge
//   reset        in   synchronous, active-high
//   pixel_ce     in   pixel advance enable; everything holds while low
//   h_synch      out  horizontal sync, active-low
//   v_synch      out  vertical sync, active-low
//   blank        out  high outside the visible region
//   pixel_x      out  horizontal count 0..H_TOTAL-1
//   pixel_y      out  vertical count 0..V_TOTAL-1
//   line_start   out  high while pixel_x == 0
//   frame_start  out  high while pixel_x == 0 and pixel_y == 0
// -----------------------------------------------------------------------------
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK
) (
  input  logic               pixel_clock,
  input  logic               reset,
  input  logic               pixel_ce,
  output logic               h_synch,
  output logic               v_synch,
  output logic               blank,
  output logic [VGA_X_W-1:0] pixel_x,
  output logic [VGA_Y_W-1:0] pixel_y,
  output logic               line_start,
  output logic               frame_start
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_FIRST = H_VISIBLE + H_FRONT;
  localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
  localparam int VS_FIRST = V_VISIBLE + V_FRONT;
  localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;

  localparam logic [VGA_X_W-1:0] X_LAST = VGA_X_W'(H_TOTAL - 1);
  localparam logic [VGA_Y_W-1:0] Y_LAST = VGA_Y_W'(V_TOTAL - 1);

  localparam bit PARAMS_BAD =
      (H_VISIBLE == 0) || (H_FRONT == 0) || (H_SYNC == 0) || (H_BACK == 0) ||
      (V_VISIBLE == 0) || (V_FRONT == 0) || (V_SYNC == 0) || (V_BACK == 0) ||
      (H_TOTAL > VGA_H_TOTAL_MAX) || (V_TOTAL > VGA_V_TOTAL_MAX);

  generate
    if (PARAMS_BAD) begin : g_bad_params
      $error("vga_timing: zero timing parameter or total exceeds counter range");
    end
  endgenerate

  logic [VGA_X_W-1:0] x_q, x_d;
  logic [VGA_Y_W-1:0] y_q, y_d;
  // Low after reset: the first enabled edge presents pixel (0,0) instead of
  // advancing, so the raster restarts cleanly from the top-left pixel.
  logic               run_q, run_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic               blank_q, blank_d;
  logic               ls_q, ls_d;
  logic               fs_q, fs_d;

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    run_d   = run_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    blank_d = blank_q;
    ls_d    = ls_q;
    fs_d    = fs_q;

    if (pixel_ce) begin
      run_d = 1'b1;
      if (!run_q) begin
        x_d = '0;
        y_d = '0;
      end else if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + VGA_Y_W'(1);
      end else begin
        x_d = x_q + VGA_X_W'(1);
      end

      // Decode from the next-state counters so flags and counters register
      // together with no skew.
      hs_d    = !in_window(int'(x_d), HS_FIRST, HS_LAST);
      vs_d    = !in_window(int'(y_d), VS_FIRST, VS_LAST);
      blank_d = (int'(x_d) >= H_VISIBLE) || (int'(y_d) >= V_VISIBLE);
      ls_d    = (x_d == '0);
      fs_d    = (x_d == '0) && (y_d == '0);
    end
  end

  // Raster state register; reset aborts any line or sync pulse in progress.
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      run_q   <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b1;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      run_q   <= run_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign h_synch     = hs_q;
  assign v_synch     = vs_q;
  assign blank       = blank_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing.sv
module tb_vga_timing;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ce;

  // Small timing set: 8/2/2/2 x 4/1/1/1 -> 14 x 7
  logic               s_hs, s_vs, s_bl, s_ls, s_fs;
  logic [VGA_X_W-1:0] s_x;
  logic [VGA_Y_W-1:0] s_y;
  // Default 640x480 set
  logic               d_hs, d_vs, d_bl, d_ls, d_fs;
  logic [VGA_X_W-1:0] d_x;
  logic [VGA_Y_W-1:0] d_y;

  vga_timing #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) u_small (
    .pixel_clock(clk), .reset(rst), .pixel_ce(ce),
    .h_synch(s_hs), .v_synch(s_vs), .blank(s_bl),
    .pixel_x(s_x), .pixel_y(s_y), .line_start(s_ls), .frame_start(s_fs)
  );

  vga_timing u_dflt (
    .pixel_clock(clk), .reset(rst), .pixel_ce(ce),
    .h_synch(d_hs), .v_synch(d_vs), .blank(d_bl),
    .pixel_x(d_x), .pixel_y(d_y), .line_start(d_ls), .frame_start(d_fs)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic r;
    logic c;
    int   x;
    int   y;
    logic h;
    logic v;
    logic b;
    logic ls;
    logic fs;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic c, input int x, input int y,
                              input logic h, input logic v, input logic b,
                              input logic ls, input logic fs);
    vec_t e;
    e.r = r; e.c = c; e.x = x; e.y = y; e.h = h; e.v = v; e.b = b; e.ls = ls; e.fs = fs;
    tbl.push_back(e);
  endfunction

  // Reference for the small set, indexed by enabled pixels since start.
  task automatic chk_small(input string tag, input int n);
    int x, y;
    x = n % 14;
    y = (n / 14) % 7;
    chk({tag, ".x"},  int'(s_x),  x);
    chk({tag, ".y"},  int'(s_y),  y);
    chk({tag, ".hs"}, int'(s_hs), (x >= 10 && x <= 11) ? 0 : 1);
    chk({tag, ".vs"}, int'(s_vs), (y == 5) ? 0 : 1);
    chk({tag, ".bl"}, int'(s_bl), (x >= 8 || y >= 4) ? 1 : 0);
    chk({tag, ".ls"}, int'(s_ls), (x == 0) ? 1 : 0);
    chk({tag, ".fs"}, int'(s_fs), (x == 0 && y == 0) ? 1 : 0);
  endtask

  bit started;
  int n;

  task automatic do_reset();
    rst = 1'b1;
    ce  = 1'($urandom_range(0, 1));
    step();
    rst = 1'b0;
    started = 1'b0;
    n = 0;
  endtask

  task automatic tick(input logic c, input string tag);
    rst = 1'b0;
    ce  = c;
    step();
    if (c) begin
      if (!started) begin
        started = 1'b1;
        n = 0;
      end else begin
        n++;
      end
    end
    if (started) chk_small(tag, n);
  endtask

  initial begin
    rst = 1'b1;
    ce  = 1'b0;
    started = 1'b0;
    n = 0;

    // r c  x  y  h v b ls fs
    add(1, 1, 0, 0, 1, 1, 1, 0, 0);
    add(1, 0, 0, 0, 1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 1, 0, 0);
    add(0, 1, 0, 0, 1, 1, 0, 1, 1);
    add(0, 1, 1, 0, 1, 1, 0, 0, 0);
    add(0, 0, 1, 0, 1, 1, 0, 0, 0);
    for (int i = 2; i < 8; i++) add(0, 1, i, 0, 1, 1, 0, 0, 0);
    add(0, 1, 8, 0, 1, 1, 1, 0, 0);
    add(0, 1, 9, 0, 1, 1, 1, 0, 0);
    add(0, 1, 10, 0, 0, 1, 1, 0, 0);
    add(0, 0, 10, 0, 0, 1, 1, 0, 0);
    add(0, 1, 11, 0, 0, 1, 1, 0, 0);
    add(0, 1, 12, 0, 1, 1, 1, 0, 0);
    add(0, 1, 13, 0, 1, 1, 1, 0, 0);
    add(0, 1, 0, 1, 1, 1, 0, 1, 0);
    add(0, 1, 1, 1, 1, 1, 0, 0, 0);
    add(1, 0, 0, 0, 1, 1, 1, 0, 0);
    add(0, 1, 0, 0, 1, 1, 0, 1, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].r;
      ce  = tbl[i].c;
      step();
      chk($sformatf("vec%0d.x", i),  int'(s_x),  tbl[i].x);
      chk($sformatf("vec%0d.y", i),  int'(s_y),  tbl[i].y);
      chk($sformatf("vec%0d.hs", i), int'(s_hs), int'(tbl[i].h));
      chk($sformatf("vec%0d.vs", i), int'(s_vs), int'(tbl[i].v));
      chk($sformatf("vec%0d.bl", i), int'(s_bl), int'(tbl[i].b));
      chk($sformatf("vec%0d.ls", i), int'(s_ls), int'(tbl[i].ls));
      chk($sformatf("vec%0d.fs", i), int'(s_fs), int'(tbl[i].fs));
    end

    // Continuous ce on the small set: periods and vertical sync window.
    begin
      int last_ls, last_fs, vlow;
      bit vseen;
      last_ls = -1; last_fs = -1; vlow = 0; vseen = 1'b0;
      do_reset();
      for (int cyc = 0; cyc < 3 * 98; cyc++) begin
        tick(1'b1, "cont");
        if (s_ls) begin
          if (last_ls >= 0) chk("line_period", cyc - last_ls, 14);
          last_ls = cyc;
        end
        if (s_fs) begin
          if (last_fs >= 0) chk("frame_period", cyc - last_fs, 98);
          last_fs = cyc;
        end
        if (cyc < 98 && !s_vs) begin
          if (!vseen) begin
            chk("vs_first_x", int'(s_x), 0);
            chk("vs_first_y", int'(s_y), 5);
            vseen = 1'b1;
          end
          vlow++;
        end
      end
      chk("vs_low_count", vlow, 14);
    end

    // ce 1-of-2
    do_reset();
    for (int cyc = 0; cyc < 120; cyc++) tick(1'(cyc % 2), "ce_half");

    // random ce
    do_reset();
    for (int cyc = 0; cyc < 300; cyc++) tick(1'($urandom_range(0, 1)), "ce_rand");

    // hold at the last pixel of the frame, then wrap on the next enabled edge
    do_reset();
    for (int cyc = 0; cyc < 98; cyc++) tick(1'b1, "to_end");
    for (int cyc = 0; cyc < 5; cyc++) tick(1'b0, "hold_end");
    chk("hold_x", int'(s_x), 13);
    chk("hold_y", int'(s_y), 6);
    tick(1'b1, "wrap");
    chk("wrap_fs", int'(s_fs), 1);

    // Default set: first pixel and one full line
    begin
      int bl_low, hs_low, hs_first, pre, post;
      bit in_sync, past_sync;
      bl_low = 0; hs_low = 0; hs_first = -1; pre = 0; post = 0;
      in_sync = 1'b0; past_sync = 1'b0;
      do_reset();
      ce = 1'b1;
      step();
      chk("d_first.x",  int'(d_x),  0);
      chk("d_first.y",  int'(d_y),  0);
      chk("d_first.bl", int'(d_bl), 0);
      chk("d_first.hs", int'(d_hs), 1);
      chk("d_first.vs", int'(d_vs), 1);
      chk("d_first.ls", int'(d_ls), 1);
      chk("d_first.fs", int'(d_fs), 1);
      for (int cyc = 0; cyc < 800; cyc++) begin
        if (cyc > 0) step();
        if (!d_bl) bl_low++;
        if (!d_hs) begin
          if (hs_first < 0) hs_first = int'(d_x);
          hs_low++;
          in_sync = 1'b1;
        end else if (in_sync) begin
          past_sync = 1'b1;
        end
        if (d_bl && d_hs && !in_sync) pre++;
        if (d_bl && d_hs && past_sync) post++;
      end
      chk("d_blank_low", bl_low, 640);
      chk("d_hs_low", hs_low, 96);
      chk("d_hs_first_x", hs_first, 656);
      chk("d_front_porch", pre, 16);
      chk("d_back_porch", post, 48);
      step();
      chk("d_line2.ls", int'(d_ls), 1);
      chk("d_line2.x",  int'(d_x),  0);
      chk("d_line2.y",  int'(d_y),  1);
    end

    // Default set: reset inside horizontal sync
    do_reset();
    ce = 1'b1;
    for (int cyc = 0; cyc < 701; cyc++) step();
    chk("pre_rst.x",  int'(d_x),  700);
    chk("pre_rst.hs", int'(d_hs), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst.x",  int'(d_x),  0);
    chk("mid_rst.y",  int'(d_y),  0);
    chk("mid_rst.hs", int'(d_hs), 1);
    chk("mid_rst.bl", int'(d_bl), 1);
    chk("mid_rst.ls", int'(d_ls), 0);
    step();
    chk("post_rst.x",  int'(d_x),  0);
    chk("post_rst.y",  int'(d_y),  0);
    chk("post_rst.bl", int'(d_bl), 0);
    chk("post_rst.hs", int'(d_hs), 1);
    chk("post_rst.fs", int'(d_fs), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
